// File: rtl/pulse_filter_pkg.sv
// Shared constants and helpers for the scheduled multi-channel pulse filter.
package pulse_filter_pkg;

    localparam int unsigned CNT_W_DEF       = 22;
    localparam int unsigned DEF_CLK_HZ      = 20_000_000;
    localparam int unsigned DEF_FILTER_MS   = 200;
    localparam int unsigned DEF_THRES_200MS = DEF_FILTER_MS * (DEF_CLK_HZ / 1000);

    // Filter time in ms -> number of service visits, given the round-robin width.
    function automatic int unsigned ms_to_visits(input int unsigned ms,
                                                 input int unsigned n_ch,
                                                 input int unsigned clk_hz);
        longint unsigned cycles;
        cycles = 64'(ms) * 64'(clk_hz) / 64'd1000;
        return 32'(cycles / 64'(n_ch));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: search starts one past the last accepted grant.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int unsigned      cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_any && req[cand]) begin
                gnt_any    = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && gnt_any) begin
            ptr_d = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pulse_filter_sched.sv
// Multi-channel debounce engine: one shared compare/increment datapath visits one channel
// per cycle round-robin; filtered-level changes are queued to a valid/ready event port.
module pulse_filter_sched
    import pulse_filter_pkg::*;
#(
    parameter  int unsigned N_CH      = 8,
    parameter  int unsigned CNT_W     = CNT_W_DEF,
    parameter  int unsigned DEF_THRES = DEF_THRES_200MS,
    localparam int unsigned CH_W      = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_CH-1:0]  pulse_in,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_thres,
    output logic [N_CH-1:0]  filt_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CH_W-1:0]  evt_ch,
    output logic             evt_level,
    output logic             slot_wrap
);

    localparam logic [CH_W-1:0]  SLOT_LAST = CH_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] THRES_RST = CNT_W'(DEF_THRES);

    logic [N_CH-1:0]  sync1_q, sync_q;
    logic [CH_W-1:0]  slot_q, slot_d;
    logic             slot_wrap_q, slot_wrap_d;
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CNT_W-1:0] thres_q [N_CH];
    logic [CNT_W-1:0] thres_d [N_CH];
    logic [N_CH-1:0]  filt_q, filt_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  flip_set, pending_clr, cfg_sel;
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic             evt_level_q, evt_level_d;

    logic [N_CH-1:0]  gnt;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic             load;

    // Out-of-range channel numbers simply match no entry.
    always_comb begin
        cfg_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            cfg_sel[k] = cfg_wr && (cfg_ch == CH_W'(k));
        end
    end

    always_comb begin
        slot_d      = slot_q;
        slot_wrap_d = 1'b0;
        if (en) begin
            slot_wrap_d = (slot_q == SLOT_LAST);
            slot_d      = slot_wrap_d ? '0 : slot_q + CH_W'(1);
        end
    end

    // Shared datapath; a config write to the serviced channel overrides the service.
    always_comb begin
        filt_d   = filt_q;
        flip_set = '0;
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k]   = cnt_q[k];
            thres_d[k] = thres_q[k];
            if (cfg_sel[k]) begin
                thres_d[k] = cfg_thres;
                cnt_d[k]   = '0;
            end else if (!en) begin
                cnt_d[k] = '0;
            end else if (slot_q == CH_W'(k)) begin
                if (sync_q[k] == filt_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] < thres_q[k]) begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end else begin
                    filt_d[k]   = sync_q[k];
                    cnt_d[k]    = '0;
                    flip_set[k] = 1'b1;
                end
            end
        end
    end

    rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (pending_q),
        .advance (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A new flip in the grant cycle re-arms pending, so no level change is dropped.
    always_comb begin
        load        = !evt_valid_q || evt_ready;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_level_d = evt_level_q;
        pending_clr = '0;
        if (load) begin
            evt_valid_d = gnt_any;
            if (gnt_any) begin
                evt_ch_d    = gnt_idx;
                evt_level_d = filt_q[gnt_idx];
                pending_clr = gnt;
            end
        end
        pending_d = (pending_q & ~pending_clr) | flip_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync_q      <= '0;
            slot_q      <= '0;
            slot_wrap_q <= 1'b0;
            filt_q      <= '0;
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_level_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k]   <= '0;
                thres_q[k] <= THRES_RST;
            end
        end else begin
            sync1_q     <= pulse_in;
            sync_q      <= sync1_q;
            slot_q      <= slot_d;
            slot_wrap_q <= slot_wrap_d;
            filt_q      <= filt_d;
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_level_q <= evt_level_d;
            cnt_q       <= cnt_d;
            thres_q     <= thres_d;
        end
    end

    assign filt_out  = filt_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_level = evt_level_q;
    assign slot_wrap = slot_wrap_q;

endmodule

// File: tb/tb_pulse_filter_sched.sv
// Directed bench for pulse_filter_sched (4 channels); accepted events are checked
// against a queue of expected (channel, level) pairs.
module tb_pulse_filter_sched;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned CNT_W     = 22;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned DEF_THRES = 5;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            level;
    } evt_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [N_CH-1:0]  pulse_in = '0;
    logic             cfg_wr = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_thres = '0;
    logic [N_CH-1:0]  filt_out;
    logic             evt_valid;
    logic             evt_ready = 1'b1;
    logic [CH_W-1:0]  evt_ch;
    logic             evt_level;
    logic             slot_wrap;

    evt_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pulse_filter_sched #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .DEF_THRES (DEF_THRES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pulse_in  (pulse_in),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_thres (cfg_thres),
        .filt_out  (filt_out),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_level (evt_level),
        .slot_wrap (slot_wrap)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int th);
        cfg_wr    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_thres = CNT_W'(th);
        step(1);
        cfg_wr    = 1'b0;
    endtask

    // Returns #1 after the edge that moved slot to 0.
    task automatic wait_wrap();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (slot_wrap !== 1'b1 && n < 8);
        check("wrap_seen", 32'(slot_wrap), 32'd1);
    endtask

    task automatic wait_filt(input int ch, input logic lvl, input int max);
        int n = 0;
        while (filt_out[ch] !== lvl && n < max) begin
            step(1);
            n++;
        end
        check("filt_reach", 32'(filt_out[ch]), 32'(lvl));
    endtask

    // Scoreboard: every accepted event must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL evt_unexpected: observed ch %0d level %0d expected no event",
                       evt_ch, evt_level);
            end
            if (sb.size() != 0) begin
                evt_t e;
                e = sb.pop_front();
                check("evt_ch", 32'(evt_ch), 32'(e.ch));
                check("evt_level", 32'(evt_level), 32'(e.level));
            end
        end
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        // Reset state and slot pointer start
        #12;
        check("rst_filt", 32'(filt_out), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_wrap", 32'(slot_wrap), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        step(3);
        check("wrap_early", 32'(slot_wrap), 32'd0);
        step(1);
        check("wrap_pulse", 32'(slot_wrap), 32'd1);
        step(1);
        check("wrap_one_cycle", 32'(slot_wrap), 32'd0);

        cfg(0, 1);
        cfg(1, 3);
        cfg(2, 3);
        cfg(3, 1);

        // 1: steady mismatch on ch2 flips on the 4th visit
        sb.push_back(evt_t'{ch: 2'd2, level: 1'b1});
        wait_wrap();
        pulse_in[2] = 1'b1;
        step(14);
        check("t1_hold", 32'(filt_out[2]), 32'd0);
        step(1);
        check("t1_flip", 32'(filt_out[2]), 32'd1);
        step(1);
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_ch", 32'(evt_ch), 32'd2);
        step(4);
        check("t1_drain", 32'(evt_valid), 32'd0);

        // 2: short glitch on ch1 is rejected
        wait_wrap();
        pulse_in[1] = 1'b1;
        step(8);
        pulse_in[1] = 1'b0;
        step(2);
        check("t2_cnt_mid", 32'(dut.cnt_q[1]), 32'd2);
        step(4);
        check("t2_cnt_clr", 32'(dut.cnt_q[1]), 32'd0);
        step(10);
        check("t2_filt", 32'(filt_out[1]), 32'd0);

        // 3: backpressure holds ch0 event, ch3 follows
        evt_ready = 1'b0;
        sb.push_back(evt_t'{ch: 2'd0, level: 1'b1});
        sb.push_back(evt_t'{ch: 2'd3, level: 1'b1});
        wait_wrap();
        pulse_in[0] = 1'b1;
        step(9);
        check("t3_ch0_flip", 32'(filt_out[0]), 32'd1);
        pulse_in[3] = 1'b1;
        step(7);
        check("t3_ch3_flip", 32'(filt_out[3]), 32'd1);
        step(4);
        check("t3_held_valid", 32'(evt_valid), 32'd1);
        check("t3_held_ch", 32'(evt_ch), 32'd0);
        check("t3_held_level", 32'(evt_level), 32'd1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("t3_next_valid", 32'(evt_valid), 32'd1);
        check("t3_next_ch", 32'(evt_ch), 32'd3);
        evt_ready = 1'b1;
        step(1);
        check("t3_empty", 32'(evt_valid), 32'd0);

        // 4: ch1 toggles twice while the port is busy -> one coalesced event
        cfg(1, 1);
        evt_ready = 1'b0;
        sb.push_back(evt_t'{ch: 2'd0, level: 1'b0});
        sb.push_back(evt_t'{ch: 2'd1, level: 1'b0});
        pulse_in[0] = 1'b0;
        wait_filt(0, 1'b0, 40);
        pulse_in[1] = 1'b1;
        wait_filt(1, 1'b1, 40);
        pulse_in[1] = 1'b0;
        wait_filt(1, 1'b0, 40);
        step(2);
        check("t4_held_ch", 32'(evt_ch), 32'd0);
        check("t4_held_level", 32'(evt_level), 32'd0);
        evt_ready = 1'b1;
        step(6);
        check("t4_empty", 32'(evt_valid), 32'd0);
        check("t4_sb", 32'(sb.size()), 32'd0);

        // 5: config write to the serviced channel suppresses that visit's flip
        sb.push_back(evt_t'{ch: 2'd2, level: 1'b0});
        wait_wrap();
        pulse_in[2] = 1'b0;
        step(14);
        check("t5_cnt_at_thres", 32'(dut.cnt_q[2]), 32'd3);
        cfg_wr    = 1'b1;
        cfg_ch    = 2'd2;
        cfg_thres = '0;
        step(1);
        cfg_wr    = 1'b0;
        check("t5_no_flip", 32'(filt_out[2]), 32'd1);
        check("t5_cnt_clr", 32'(dut.cnt_q[2]), 32'd0);
        step(3);
        check("t5_still", 32'(filt_out[2]), 32'd1);
        step(1);
        check("t5_flip", 32'(filt_out[2]), 32'd0);
        step(4);

        // 6: reset mid-filter with an event pending on the port
        evt_ready   = 1'b0;
        pulse_in[1] = 1'b1;
        wait_filt(1, 1'b1, 40);
        step(2);
        check("t6_pre_valid", 32'(evt_valid), 32'd1);
        check("t6_pre_ch", 32'(evt_ch), 32'd1);
        cfg(0, 10);
        wait_wrap();
        pulse_in[0] = 1'b1;
        step(9);
        check("t6_pre_cnt", 32'(dut.cnt_q[0]), 32'd2);
        rst_n       = 1'b0;
        pulse_in[1] = 1'b0;
        pulse_in[3] = 1'b0;
        #1;
        check("t6_rst_filt", 32'(filt_out), 32'd0);
        check("t6_rst_valid", 32'(evt_valid), 32'd0);
        check("t6_rst_cnt", 32'(dut.cnt_q[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        sb.push_back(evt_t'{ch: 2'd0, level: 1'b1});
        step(3);
        check("t6_wrap_early", 32'(slot_wrap), 32'd0);
        step(1);
        check("t6_wrap", 32'(slot_wrap), 32'd1);
        // Threshold back at DEF_THRES=5: flip on the 6th mismatching visit
        step(20);
        check("t6_def_hold", 32'(filt_out[0]), 32'd0);
        step(1);
        check("t6_def_flip", 32'(filt_out[0]), 32'd1);
        step(4);
        check("t6_empty", 32'(evt_valid), 32'd0);
        check("t6_sb", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
